fb_scan_reader: RTL and testbench

- Display-side reader for the double-buffered pixel DRAM that the blitter address generator fills during blanking.
- For each line it fetches 128 pixel-pair bytes from the buffer the blitter is not writing (opposite frame parity), using the same multiplexed row/column address split.
- It serializes each byte into two 4-bit pixels and applies the latched H/V flips.
- It emits transparency and behind-background priority flags for the mixer.

---
 rtl/fb_scan_reader_if.sv | 8 +
 rtl/fb_scan_reader.sv | 97 +++++++++
 tb/tb_fb_scan_reader.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fb_scan_reader_if.sv
// fb_scan_reader_if: multiplexed pixel DRAM read bus between the scan reader and the buffer memory
interface fb_scan_reader_if;
  logic [7:0] DRAM_A;
  logic       DRAM_OE;
  logic [7:0] DRAM_D;
  modport master (output DRAM_A, DRAM_OE, input DRAM_D);
  modport slave  (input DRAM_A, DRAM_OE, output DRAM_D);
endinterface

// File: rtl/fb_scan_reader.sv
// fb_scan_reader: fetches one line of pixel pairs from the idle frame buffer and serializes flipped pixels
module fb_scan_reader #(
  parameter int         PAIRS      = 128,
  parameter logic [3:0] PRIO_COLOR = 4'd7
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             HSTART,
  input  logic [7:0]       LINE_Y,
  input  logic             FRAME,
  input  logic             XF,
  input  logic             YF,
  fb_scan_reader_if.master dram,
  output logic [3:0]       PIX,
  output logic             PIX_VALID,
  output logic             PIX_OPAQUE,
  output logic             PIX_BEHIND,
  output logic             LINE_BUSY,
  output logic             LINE_DONE
);
  localparam int KW = $clog2(PAIRS);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t      state;
  logic [KW:0] cnt;
  logic [KW:0] nxt;
  logic [7:0]  ye;
  logic [7:0]  ye_in;
  logic        par;
  logic        xf;
  logic [3:0]  hold;
  logic        go;
  function automatic logic [7:0] addr(logic [KW:0] c, logic p, logic [7:0] y, logic f);
    return c[0] ? {y[0], f ? ~c[KW:1] : c[KW:1]} : {p, y[7:1]};
  endfunction
  assign go         = HSTART && (state == IDLE || state == DONE);
  assign ye_in      = YF ? ~LINE_Y : LINE_Y;
  assign nxt        = cnt + 1'b1;
  assign LINE_BUSY  = state != IDLE;
  assign LINE_DONE  = state == DONE;
  assign PIX_OPAQUE = PIX != 4'd0;
  assign PIX_BEHIND = PIX == PRIO_COLOR;
  // even cnt is a row phase, odd cnt the column phase whose byte lands at the cycle's end
  always_ff @(posedge CLK)
    if (!nRESET) begin
      state        <= IDLE;
      cnt          <= '0;
      ye           <= '0;
      par          <= 1'b0;
      xf           <= 1'b0;
      hold         <= '0;
      PIX          <= '0;
      PIX_VALID    <= 1'b0;
      dram.DRAM_A  <= '0;
      dram.DRAM_OE <= 1'b0;
    end else if (go) begin
      state        <= FETCH;
      cnt          <= '0;
      ye           <= ye_in;
      par          <= ~FRAME;
      xf           <= XF;
      dram.DRAM_A  <= addr('0, ~FRAME, ye_in, XF);
      dram.DRAM_OE <= 1'b0;
      PIX          <= '0;
      PIX_VALID    <= 1'b0;
    end else
      case (state)
        FETCH: begin
          if (cnt[0]) begin
            PIX       <= xf ? dram.DRAM_D[7:4] : dram.DRAM_D[3:0];
            hold      <= xf ? dram.DRAM_D[3:0] : dram.DRAM_D[7:4];
            PIX_VALID <= 1'b1;
          end else if (cnt != '0)
            PIX <= hold;
          if (&cnt) begin
            state        <= DRAIN;
            cnt          <= '0;
            dram.DRAM_A  <= '0;
            dram.DRAM_OE <= 1'b0;
          end else begin
            cnt          <= nxt;
            dram.DRAM_A  <= addr(nxt, par, ye, xf);
            dram.DRAM_OE <= nxt[0];
          end
        end
        DRAIN:
          if (cnt[0]) begin
            state     <= DONE;
            PIX       <= '0;
            PIX_VALID <= 1'b0;
          end else begin
            PIX <= hold;
            cnt <= nxt;
          end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_fb_scan_reader.sv
// tb_fb_scan_reader: directed checks of fetch addressing, pixel order, flags, handshake and reset
module tb_fb_scan_reader;
  logic       CLK = 0, nRESET = 0, HSTART = 0, FRAME = 0, XF = 0, YF = 0, dm = 0;
  logic [7:0] LINE_Y = 0;
  logic [3:0] PIX;
  logic       PIX_VALID, PIX_OPAQUE, PIX_BEHIND, LINE_BUSY, LINE_DONE;
  int         checks = 0, failures = 0;
  logic [17:0] cap [0:600];
  fb_scan_reader_if dram();
  assign dram.DRAM_D = (dm && dram.DRAM_A == 8'h80) ? 8'h70 : dram.DRAM_A;
  fb_scan_reader dut (
    .CLK(CLK), .nRESET(nRESET), .HSTART(HSTART), .LINE_Y(LINE_Y), .FRAME(FRAME),
    .XF(XF), .YF(YF), .dram(dram), .PIX(PIX), .PIX_VALID(PIX_VALID),
    .PIX_OPAQUE(PIX_OPAQUE), .PIX_BEHIND(PIX_BEHIND), .LINE_BUSY(LINE_BUSY), .LINE_DONE(LINE_DONE)
  );
  always #5 CLK = ~CLK;
  // {addr, oe, pix, valid, opaque, behind, done, busy} expected i cycles after HSTART acceptance
  function automatic logic [17:0] exp_vec(int i, logic fr, logic [7:0] ye, logic xfl, logic dmode);
    logic [7:0] a, b;
    logic       oe, v;
    logic [3:0] p;
    int         k;
    a = 0; oe = 0; p = 0; v = 0;
    if (i >= 1 && i <= 256) begin
      oe = (i % 2 == 0);
      k  = (i - 1) / 2;
      a  = oe ? {ye[0], xfl ? 7'(127 - k) : 7'(k)} : {~fr, ye[7:1]};
    end
    if (i >= 3 && i <= 258) begin
      k = (i - 3) / 2;
      b = {ye[0], xfl ? 7'(127 - k) : 7'(k)};
      if (dmode && b == 8'h80) b = 8'h70;
      v = 1;
      p = (((i - 3) % 2 == 0) ^ xfl) ? b[3:0] : b[7:4];
    end
    return {a, oe, p, v, p != 4'd0, p == 4'd7, i == 259, i >= 1 && i <= 259};
  endfunction
  task automatic start_line(input logic [7:0] y, input logic fr, input logic x, input logic yv);
    @(negedge CLK);
    LINE_Y = y; FRAME = fr; XF = x; YF = yv; HSTART = 1;
    @(negedge CLK);
    HSTART = 0;
  endtask
  task automatic capture(input int n, input int p1, input int p2, input int r);
    for (int i = 1; i <= n; i++) begin
      cap[i] = {dram.DRAM_A, dram.DRAM_OE, PIX, PIX_VALID, PIX_OPAQUE, PIX_BEHIND, LINE_DONE, LINE_BUSY};
      HSTART = (i == p1 || i == p2);
      nRESET = (i != r);
      if (i == p1) begin LINE_Y = 8'hAA; FRAME = 1; XF = 1; YF = 1; end
      if (i == p2) begin LINE_Y = 8'h05; FRAME = 0; XF = 0; YF = 0; end
      @(negedge CLK);
    end
    HSTART = 0; nRESET = 1;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge CLK);
    checks++;
    if ({dram.DRAM_A, dram.DRAM_OE} !== 9'h0) begin $display("FAIL reset_dram got=%h exp=0", {dram.DRAM_A, dram.DRAM_OE}); failures++; end
    checks++;
    if ({PIX, PIX_VALID, PIX_OPAQUE, PIX_BEHIND} !== 7'h0) begin $display("FAIL reset_pix got=%h exp=0", {PIX, PIX_VALID, PIX_OPAQUE, PIX_BEHIND}); failures++; end
    checks++;
    if ({LINE_BUSY, LINE_DONE} !== 2'b00) begin $display("FAIL reset_line got=%b exp=00", {LINE_BUSY, LINE_DONE}); failures++; end
    nRESET = 1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({LINE_BUSY, dram.DRAM_OE} !== 2'b00) begin $display("FAIL idle_no_hstart got=%b exp=00", {LINE_BUSY, dram.DRAM_OE}); failures++; end
  endtask
  task automatic test_basic;
    int bad, nv;
    logic [17:0] e;
    start_line(8'h05, 0, 0, 0);
    capture(261, 0, 0, 0);
    bad = 0;
    for (int i = 1; i <= 260; i++) begin
      e = exp_vec(i, 0, 8'h05, 0, 0);
      if (!bad && cap[i] !== e) begin $display("FAIL basic_seq cycle=%0d got=%h exp=%h", i, cap[i], e); bad = 1; end
    end
    checks++; failures += bad;
    checks++;
    if (cap[1][17:10] !== 8'h82) begin $display("FAIL basic_row got=%h exp=82", cap[1][17:10]); failures++; end
    checks++;
    if ({cap[2][17:10], cap[256][17:10]} !== 16'h80FF) begin $display("FAIL basic_cols got=%h exp=80ff", {cap[2][17:10], cap[256][17:10]}); failures++; end
    checks++;
    if ({cap[3][8:5], cap[4][8:5]} !== 8'h08) begin $display("FAIL basic_first_pix got=%h exp=08", {cap[3][8:5], cap[4][8:5]}); failures++; end
    nv = 0;
    for (int i = 1; i <= 261; i++) nv += int'(cap[i][4]);
    checks++;
    if (nv != 256) begin $display("FAIL basic_valid_len got=%0d exp=256", nv); failures++; end
    checks++;
    if ({cap[258][1], cap[259][1], cap[260][1]} !== 3'b010) begin $display("FAIL basic_done got=%b exp=010", {cap[258][1], cap[259][1], cap[260][1]}); failures++; end
  endtask
  task automatic test_xflip;
    int bad;
    logic [17:0] e;
    start_line(8'h05, 0, 1, 0);
    capture(261, 0, 0, 0);
    bad = 0;
    for (int i = 1; i <= 260; i++) begin
      e = exp_vec(i, 0, 8'h05, 1, 0);
      if (!bad && cap[i] !== e) begin $display("FAIL xflip_seq cycle=%0d got=%h exp=%h", i, cap[i], e); bad = 1; end
    end
    checks++; failures += bad;
    checks++;
    if ({cap[2][17:10], cap[256][17:10]} !== 16'hFF80) begin $display("FAIL xflip_cols got=%h exp=ff80", {cap[2][17:10], cap[256][17:10]}); failures++; end
    checks++;
    if ({cap[5][8:5], cap[6][8:5]} !== 8'hFE) begin $display("FAIL xflip_order got=%h exp=fe", {cap[5][8:5], cap[6][8:5]}); failures++; end
  endtask
  task automatic test_yflip;
    int bad;
    logic [17:0] e;
    start_line(8'h05, 0, 1, 1);
    capture(261, 0, 0, 0);
    bad = 0;
    for (int i = 1; i <= 260; i++) begin
      e = exp_vec(i, 0, 8'hFA, 1, 0);
      if (!bad && cap[i] !== e) begin $display("FAIL yflip_seq cycle=%0d got=%h exp=%h", i, cap[i], e); bad = 1; end
    end
    checks++; failures += bad;
    checks++;
    if ({cap[1][17:10], cap[255][17:10]} !== 16'hFDFD) begin $display("FAIL yflip_row got=%h exp=fdfd", {cap[1][17:10], cap[255][17:10]}); failures++; end
    checks++;
    if ({cap[2][17:10], cap[256][17:10]} !== 16'h7F00) begin $display("FAIL yflip_cols got=%h exp=7f00", {cap[2][17:10], cap[256][17:10]}); failures++; end
  endtask
  task automatic test_priority;
    int bad;
    logic [17:0] e;
    dm = 1;
    start_line(8'h05, 0, 0, 0);
    capture(261, 0, 0, 0);
    dm = 0;
    bad = 0;
    for (int i = 1; i <= 260; i++) begin
      e = exp_vec(i, 0, 8'h05, 0, 1);
      if (!bad && cap[i] !== e) begin $display("FAIL prio_seq cycle=%0d got=%h exp=%h", i, cap[i], e); bad = 1; end
    end
    checks++; failures += bad;
    checks++;
    if (cap[3][8:2] !== 7'b0000_100) begin $display("FAIL prio_transparent got=%b exp=0000100", cap[3][8:2]); failures++; end
    checks++;
    if (cap[4][8:2] !== 7'b0111_111) begin $display("FAIL prio_behind got=%b exp=0111111", cap[4][8:2]); failures++; end
  endtask
  task automatic test_back_to_back;
    int bad;
    logic [17:0] e;
    start_line(8'h05, 0, 0, 0);
    capture(520, 50, 259, 0);
    bad = 0;
    for (int i = 1; i <= 259; i++) begin
      e = exp_vec(i, 0, 8'h05, 0, 0);
      if (!bad && cap[i] !== e) begin $display("FAIL hs_ignored_seq cycle=%0d got=%h exp=%h", i, cap[i], e); bad = 1; end
    end
    checks++; failures += bad;
    bad = 0;
    for (int i = 260; i <= 519; i++) begin
      e = exp_vec(i - 259, 0, 8'h05, 0, 0);
      if (!bad && cap[i] !== e) begin $display("FAIL b2b_seq cycle=%0d got=%h exp=%h", i, cap[i], e); bad = 1; end
    end
    checks++; failures += bad;
    checks++;
    if ({cap[260][17:9], cap[260][0]} !== {8'h82, 1'b0, 1'b1}) begin $display("FAIL b2b_row got=%h exp=%h", {cap[260][17:9], cap[260][0]}, {8'h82, 1'b0, 1'b1}); failures++; end
    checks++;
    if ({cap[261][4], cap[262][4], cap[262][8:5], cap[263][8:5]} !== 10'b01_0000_1000) begin $display("FAIL b2b_first_pix got=%b exp=0100001000", {cap[261][4], cap[262][4], cap[262][8:5], cap[263][8:5]}); failures++; end
  endtask
  task automatic test_reset_mid;
    int bad;
    logic [17:0] e;
    start_line(8'h05, 0, 0, 0);
    capture(300, 0, 0, 81);
    checks++;
    if ({cap[81][9], cap[81][0]} !== 2'b01) begin $display("FAIL mid_before got=%b exp=01", {cap[81][9], cap[81][0]}); failures++; end
    checks++;
    if (cap[82] !== 18'h0) begin $display("FAIL mid_reset_outputs got=%h exp=0", cap[82]); failures++; end
    bad = 0;
    for (int i = 82; i <= 300; i++)
      if (!bad && cap[i][1] !== 1'b0) begin $display("FAIL mid_no_done cycle=%0d got=%b exp=0", i, cap[i][1]); bad = 1; end
    checks++; failures += bad;
    start_line(8'h05, 0, 0, 0);
    capture(6, 0, 0, 0);
    bad = 0;
    for (int i = 1; i <= 6; i++) begin
      e = exp_vec(i, 0, 8'h05, 0, 0);
      if (!bad && cap[i] !== e) begin $display("FAIL mid_restart cycle=%0d got=%h exp=%h", i, cap[i], e); bad = 1; end
    end
    checks++; failures += bad;
  endtask
  initial begin
    test_reset;
    test_basic;
    test_xflip;
    test_yflip;
    test_priority;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
